// File: rtl/writeback_commit_rob_pkg.sv
// rtl/writeback_commit_rob_pkg.sv - shared types and age helper for the writeback/commit ROB
package writeback_commit_rob_pkg;

    localparam int max_seq_bits  = 8;
    localparam int max_preg_bits = 8;

    typedef struct packed {
        logic [31:0]              pc;
        logic [4:0]               waddr;
        logic [max_preg_bits-1:0] preg;
        logic [31:0]              wdata;
        logic                     wen;
    } rob_entry_t;

    // Distance of s from head in ROB order, masked to the real sequence width.
    function automatic logic [max_seq_bits-1:0] age_of(
        input logic [max_seq_bits-1:0] s,
        input logic [max_seq_bits-1:0] head,
        input int unsigned             seq_bits
    );
        logic [max_seq_bits-1:0] mask;
        mask = max_seq_bits'((16'd1 << seq_bits) - 16'd1);
        return (s - head) & mask;
    endfunction

endpackage

// File: rtl/writeback_commit_rob_rr_arbiter.sv
// rtl/writeback_commit_rob_rr_arbiter.sv - round-robin arbiter with registered priority pointer
module wcu_rr_arbiter #(
    parameter int p_num_pipes = 4,
    parameter int p_idx_bits  = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [p_num_pipes-1:0] req,
    output logic [p_num_pipes-1:0] grant,
    output logic [p_idx_bits-1:0]  grant_idx
);

    logic [p_idx_bits-1:0] ptr;
    logic [p_idx_bits-1:0] cand;
    logic                  found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < p_num_pipes; i++) begin
            cand = p_idx_bits'((int'(ptr) + i) % p_num_pipes);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (|req) begin
            ptr <= (grant_idx == p_idx_bits'(p_num_pipes - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/writeback_commit_rob.sv
// rtl/writeback_commit_rob.sv - writeback arbitration, reorder buffer and multi-wide in-order commit
module writeback_commit_rob
    import writeback_commit_rob_pkg::*;
#(
    parameter int p_num_pipes      = 4,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6,
    parameter int p_commit_width   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [p_num_pipes-1:0]      ex_val,
    output logic [p_num_pipes-1:0]      ex_rdy,
    input  logic [p_seq_num_bits-1:0]   ex_seq_num [p_num_pipes],
    input  logic [31:0]                 ex_pc      [p_num_pipes],
    input  logic [4:0]                  ex_waddr   [p_num_pipes],
    input  logic [p_phys_addr_bits-1:0] ex_preg    [p_num_pipes],
    input  logic [31:0]                 ex_wdata   [p_num_pipes],
    input  logic [p_num_pipes-1:0]      ex_wen,
    output logic                        complete_val,
    output logic [p_seq_num_bits-1:0]   complete_seq_num,
    output logic [4:0]                  complete_waddr,
    output logic [p_phys_addr_bits-1:0] complete_preg,
    output logic [31:0]                 complete_wdata,
    output logic                        complete_wen,
    output logic [p_commit_width-1:0]   commit_val,
    output logic [p_seq_num_bits-1:0]   commit_seq_num [p_commit_width],
    output logic [31:0]                 commit_pc      [p_commit_width],
    output logic [4:0]                  commit_waddr   [p_commit_width],
    output logic [p_phys_addr_bits-1:0] commit_preg    [p_commit_width],
    output logic [31:0]                 commit_wdata   [p_commit_width],
    output logic [p_commit_width-1:0]   commit_wen,
    input  logic                        squash_val,
    input  logic [p_seq_num_bits-1:0]   squash_seq_num
);

    localparam int depth    = 1 << p_seq_num_bits;
    localparam int idx_bits = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

    rob_entry_t                 mem [depth];
    logic [depth-1:0]           valid;
    logic [depth-1:0]           elig;
    logic [p_seq_num_bits-1:0]  head;

    logic [p_num_pipes-1:0]     grant;
    logic [idx_bits-1:0]        sel;
    logic                       wr_en;
    logic [p_seq_num_bits-1:0]  wr_seq;
    logic [max_seq_bits-1:0]    sq_age;
    rob_entry_t                 wr_entry;

    logic [p_seq_num_bits-1:0]  cidx [p_commit_width];
    logic [p_commit_width-1:0]  take;
    logic [2:0]                 n_commit;
    logic                       run_open;

    wcu_rr_arbiter #(
        .p_num_pipes (p_num_pipes),
        .p_idx_bits  (idx_bits)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (ex_val),
        .grant     (grant),
        .grant_idx (sel)
    );

    assign ex_rdy = rst ? grant : '0;
    assign wr_seq = ex_seq_num[sel];
    assign sq_age = age_of(max_seq_bits'(squash_seq_num), max_seq_bits'(head), p_seq_num_bits);

    // Younger-than-squash writebacks are still handshaken so the pipe can drop them.
    assign wr_en = (|ex_rdy) &&
                   !(squash_val &&
                     age_of(max_seq_bits'(wr_seq), max_seq_bits'(head), p_seq_num_bits) > sq_age);

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = ex_pc[sel];
        wr_entry.waddr = ex_waddr[sel];
        wr_entry.preg  = max_preg_bits'(ex_preg[sel]);
        wr_entry.wdata = ex_wdata[sel];
        wr_entry.wen   = ex_wen[sel];
    end

    always_comb begin
        elig = '0;
        for (int e = 0; e < depth; e++) begin
            elig[e] = valid[e] &&
                      !(squash_val &&
                        age_of(max_seq_bits'(e), max_seq_bits'(head), p_seq_num_bits) > sq_age);
        end
    end

    // Commit run: consecutive eligible entries from head, stopping at the first hole.
    always_comb begin
        take     = '0;
        n_commit = '0;
        run_open = 1'b1;
        for (int k = 0; k < p_commit_width; k++) begin
            cidx[k] = head + p_seq_num_bits'(k);
            take[k] = run_open && elig[cidx[k]];
            run_open = take[k];
            if (take[k]) n_commit = n_commit + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head         <= '0;
            valid        <= '0;
            complete_val <= 1'b0;
            commit_val   <= '0;
        end else begin
            head         <= head + p_seq_num_bits'(n_commit);
            complete_val <= wr_en;
            commit_val   <= take;
            valid        <= elig;
            for (int k = 0; k < p_commit_width; k++) begin
                if (take[k]) valid[cidx[k]] <= 1'b0;
            end
            if (wr_en) valid[wr_seq] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_seq] <= wr_entry;
        complete_seq_num <= wr_seq;
        complete_waddr   <= wr_entry.waddr;
        complete_preg    <= p_phys_addr_bits'(wr_entry.preg);
        complete_wdata   <= wr_entry.wdata;
        complete_wen     <= wr_entry.wen;
        for (int k = 0; k < p_commit_width; k++) begin
            commit_seq_num[k] <= cidx[k];
            commit_pc[k]      <= mem[cidx[k]].pc;
            commit_waddr[k]   <= mem[cidx[k]].waddr;
            commit_preg[k]    <= p_phys_addr_bits'(mem[cidx[k]].preg);
            commit_wdata[k]   <= mem[cidx[k]].wdata;
            commit_wen[k]     <= mem[cidx[k]].wen;
        end
    end

    wr_unique: assert property (@(posedge clk) disable iff (!rst) wr_en |-> !valid[wr_seq])
        else $error("writeback to already-valid ROB entry");

endmodule
